// File: rtl/scroller_pkg.sv
// Shared types and helpers for the obstacle scroller.
//   state_t      : top-level game state
//   coord_t      : signed working width for all geometry compares
//   lfsr_step    : one step of the 8-bit Galois LFSR (right shift, taps 0xB8)
//   rect_overlap : inclusive-bounds overlap test of two axis-aligned rectangles
package scroller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Wide enough that x_left+OBS_W and y-PLAYER_SZ never wrap for any legal
  // parameter set (X_W and Y_W stay well below this).
  localparam int COORD_W = 16;
  typedef logic signed [COORD_W-1:0] coord_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic rect_overlap(
    input coord_t ax0, input coord_t ax1, input coord_t ay0, input coord_t ay1,
    input coord_t bx0, input coord_t bx1, input coord_t by0, input coord_t by1
  );
    return (ax0 <= bx1) && (bx0 <= ax1) && (ay0 <= by1) && (by0 <= ay1);
  endfunction

endpackage

// File: rtl/obstacle_lane.sv
// One tree lane: x position, height LFSR and banana-consumed flag, plus the
// combinational overlap tests against the player box and the pixel query.
//   clk, reset        : clock, async active-low reset
//   tick              : scroll one pixel left (or respawn at the left edge)
//   reinit            : restart positions, step LFSR, clear consumed
//   pickup            : banana collected this cycle
//   player_x/player_y : player left x / bottom y
//   px/py             : pixel query
//   x_left            : current left edge (signed)
//   tree_hit/item_hit : player overlaps tree / unconsumed banana
//   pix_tree/pix_item : pixel lies on tree / unconsumed banana
module obstacle_lane
  import scroller_pkg::*;
#(
  parameter int LANE         = 0,
  parameter int NUM_OBS      = 3,
  parameter int X_W          = 11,
  parameter int Y_W          = 10,
  parameter int GROUND_Y     = 400,
  parameter int OBS_W        = 80,
  parameter int SPACING      = 240,
  parameter int FIRST_X      = 160,
  parameter int H_MIN        = 140,
  parameter int H_RANGE_LOG2 = 8,
  parameter int ITEM_INSET   = 20,
  parameter int ITEM_GAP     = 30,
  parameter int ITEM_H       = 30,
  parameter int PLAYER_SZ    = 30
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           reinit,
  input  logic           pickup,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic [X_W-1:0] x_left,
  output logic           tree_hit,
  output logic           item_hit,
  output logic           pix_tree,
  output logic           pix_item
);

  localparam logic [X_W-1:0] X_INIT  = X_W'(FIRST_X + LANE * SPACING);
  localparam logic [X_W-1:0] X_EDGE  = X_W'(-OBS_W);
  localparam logic [X_W-1:0] X_WRAP  = X_W'(NUM_OBS * SPACING - OBS_W);
  localparam logic [7:0]     SEED    = LFSR_SEED ^ 8'(LANE);

  localparam coord_t C_W1    = coord_t'(OBS_W - 1);
  localparam coord_t C_INS   = coord_t'(ITEM_INSET);
  localparam coord_t C_GND1  = coord_t'(GROUND_Y - 1);
  localparam coord_t C_BTOP  = coord_t'(ITEM_GAP + ITEM_H);
  localparam coord_t C_BBOT  = coord_t'(ITEM_GAP + 1);
  localparam coord_t C_PS1   = coord_t'(PLAYER_SZ - 1);

  logic [7:0]     lfsr;
  logic           consumed;
  logic [Y_W-1:0] top;

  // Height follows the LFSR directly, so every LFSR step reloads it.
  assign top = Y_W'(H_MIN) + {{(Y_W-H_RANGE_LOG2){1'b0}}, lfsr[H_RANGE_LOG2-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_left   <= X_INIT;
      lfsr     <= SEED;
      consumed <= 1'b0;
    end else if (reinit) begin
      x_left   <= X_INIT;
      lfsr     <= lfsr_step(lfsr);
      consumed <= 1'b0;
    end else if (tick && (x_left == X_EDGE)) begin
      x_left   <= X_WRAP;
      lfsr     <= lfsr_step(lfsr);
      consumed <= 1'b0;
    end else begin
      if (tick)   x_left   <= x_left - X_W'(1);
      if (pickup) consumed <= 1'b1;
    end
  end

  coord_t xl, pl_x, pl_y, q_x, q_y, top_c;
  coord_t tr_x0, tr_x1, tr_y0, tr_y1;
  coord_t bn_x0, bn_x1, bn_y0, bn_y1;
  coord_t pl_x1, pl_y0;

  assign xl    = {{(COORD_W-X_W){x_left[X_W-1]}}, x_left};
  assign pl_x  = {{(COORD_W-X_W){player_x[X_W-1]}}, player_x};
  assign q_x   = {{(COORD_W-X_W){px[X_W-1]}}, px};
  assign pl_y  = {{(COORD_W-Y_W){1'b0}}, player_y};
  assign q_y   = {{(COORD_W-Y_W){1'b0}}, py};
  assign top_c = {{(COORD_W-Y_W){1'b0}}, top};

  assign tr_x0 = xl;
  assign tr_x1 = xl + C_W1;
  assign tr_y0 = top_c;
  assign tr_y1 = C_GND1;

  assign bn_x0 = xl + C_INS;
  assign bn_x1 = xl + C_W1 - C_INS;
  assign bn_y0 = top_c - C_BTOP;
  assign bn_y1 = top_c - C_BBOT;

  assign pl_x1 = pl_x + C_PS1;
  assign pl_y0 = pl_y - C_PS1;

  assign tree_hit = rect_overlap(tr_x0, tr_x1, tr_y0, tr_y1, pl_x, pl_x1, pl_y0, pl_y);
  assign item_hit = !consumed &&
                    rect_overlap(bn_x0, bn_x1, bn_y0, bn_y1, pl_x, pl_x1, pl_y0, pl_y);

  // A pixel is a 1x1 rectangle.
  assign pix_tree = rect_overlap(tr_x0, tr_x1, tr_y0, tr_y1, q_x, q_x, q_y, q_y);
  assign pix_item = !consumed &&
                    rect_overlap(bn_x0, bn_x1, bn_y0, bn_y1, q_x, q_x, q_y, q_y);

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle engine: NUM_OBS scrolling tree lanes with bananas, game FSM,
// scroll prescaler, player collision / pickup and registered pixel lookup.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | scrolling, collision and pickup active
//   PAUSE | freeze held; everything holds
//   HALT  | player hit a tree; start restarts the round
//
//   clk, reset           : clock, async active-low reset
//   start, freeze, speed : game controls (step period = PRESCALE>>speed)
//   player_x, player_y   : player left x / bottom y
//   px, py               : pixel query
//   pix_obs, pix_item    : registered pixel classification
//   pix_ch               : lowest matching lane
//   collide              : sticky tree hit
//   item_taken           : one-cycle pickup pulse per lane
//   running              : state is RUN
//   obs_x                : packed lane x_left, lane 0 in the LSBs
module obstacle_scroller
  import scroller_pkg::*;
#(
  parameter int NUM_OBS      = 3,
  parameter int X_W          = 11,
  parameter int Y_W          = 10,
  parameter int SCREEN_W     = 640,
  parameter int GROUND_Y     = 400,
  parameter int OBS_W        = 80,
  parameter int SPACING      = 240,
  parameter int FIRST_X      = 160,
  parameter int H_MIN        = 140,
  parameter int H_RANGE_LOG2 = 8,
  parameter int ITEM_INSET   = 20,
  parameter int ITEM_GAP     = 30,
  parameter int ITEM_H       = 30,
  parameter int PLAYER_SZ    = 30,
  parameter int PRESCALE     = 500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   freeze,
  input  logic [1:0]             speed,
  input  logic [X_W-1:0]         player_x,
  input  logic [Y_W-1:0]         player_y,
  input  logic [X_W-1:0]         px,
  input  logic [Y_W-1:0]         py,
  output logic                   pix_obs,
  output logic                   pix_item,
  output logic [2:0]             pix_ch,
  output logic                   collide,
  output logic [NUM_OBS-1:0]     item_taken,
  output logic                   running,
  output logic [NUM_OBS*X_W-1:0] obs_x
);

  if (NUM_OBS < 1 || NUM_OBS > 8) begin : g_bad_num_obs
    $error("obstacle_scroller: NUM_OBS must be 1..8");
  end
  if (NUM_OBS * SPACING - OBS_W < SCREEN_W) begin : g_bad_wrap
    $error("obstacle_scroller: respawn x would land on screen");
  end

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t state, state_next;
  logic [PW-1:0] cnt;
  logic [PW-1:0] term;
  logic          tick;
  logic          reinit;

  logic [NUM_OBS-1:0] tree_hit, item_hit, pix_tree, pix_ban, pickup;
  logic               tree_any;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (tree_any)    state_next = HALT;
        else if (freeze) state_next = PAUSE;
      end
      PAUSE:   if (!freeze) state_next = RUN;
      HALT:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign reinit  = (state == HALT) && start;

  // ---------------- prescaler ----------------
  // Terminal follows speed combinationally; a count already past a lowered
  // terminal simply runs on to the counter wrap before matching again.
  assign term = PW'((PRESCALE >> speed) - 1);
  assign tick = (state == RUN) && (cnt == term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt <= '0;
    else if (reinit)          cnt <= '0;
    else if (state == RUN)    cnt <= (cnt == term) ? '0 : cnt + PW'(1);
  end

  // ---------------- lanes ----------------
  for (genvar i = 0; i < NUM_OBS; i++) begin : g_lane
    obstacle_lane #(
      .LANE(i), .NUM_OBS(NUM_OBS), .X_W(X_W), .Y_W(Y_W), .GROUND_Y(GROUND_Y),
      .OBS_W(OBS_W), .SPACING(SPACING), .FIRST_X(FIRST_X), .H_MIN(H_MIN),
      .H_RANGE_LOG2(H_RANGE_LOG2), .ITEM_INSET(ITEM_INSET), .ITEM_GAP(ITEM_GAP),
      .ITEM_H(ITEM_H), .PLAYER_SZ(PLAYER_SZ)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .reinit   (reinit),
      .pickup   (pickup[i]),
      .player_x (player_x),
      .player_y (player_y),
      .px       (px),
      .py       (py),
      .x_left   (obs_x[i*X_W +: X_W]),
      .tree_hit (tree_hit[i]),
      .item_hit (item_hit[i]),
      .pix_tree (pix_tree[i]),
      .pix_item (pix_ban[i])
    );
  end

  // ---------------- collision / pickup ----------------
  // A tree hit suppresses every pickup in the same cycle.
  assign tree_any = |tree_hit;
  assign pickup   = ((state == RUN) && !tree_any) ? item_hit : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collide    <= 1'b0;
      item_taken <= '0;
    end else begin
      item_taken <= pickup;
      if (reinit)                            collide <= 1'b0;
      else if ((state == RUN) && tree_any)   collide <= 1'b1;
    end
  end

  // ---------------- pixel path ----------------
  logic [NUM_OBS-1:0] pix_any;
  logic [2:0]         ch_next;

  assign pix_any = pix_tree | pix_ban;

  always_comb begin
    ch_next = 3'd0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (pix_any[i]) ch_next = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_obs  <= 1'b0;
      pix_item <= 1'b0;
      pix_ch   <= 3'd0;
    end else begin
      pix_obs  <= |pix_tree;
      pix_item <= |pix_ban;
      pix_ch   <= ch_next;
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
module tb_obstacle_scroller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        freeze;
  logic [1:0]  speed;
  logic [10:0] player_x;
  logic [9:0]  player_y;
  logic [10:0] px;
  logic [9:0]  py;
  logic        pix_obs;
  logic        pix_item;
  logic [2:0]  pix_ch;
  logic        collide;
  logic [2:0]  item_taken;
  logic        running;
  logic [32:0] obs_x;

  int checks   = 0;
  int failures = 0;

  obstacle_scroller #(
    .PRESCALE  (4),
    .PLAYER_SZ (40)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .freeze     (freeze),
    .speed      (speed),
    .player_x   (player_x),
    .player_y   (player_y),
    .px         (px),
    .py         (py),
    .pix_obs    (pix_obs),
    .pix_item   (pix_item),
    .pix_ch     (pix_ch),
    .collide    (collide),
    .item_taken (item_taken),
    .running    (running),
    .obs_x      (obs_x)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; freeze = 1'b0; speed = 2'd0;
    player_x = 11'd0; player_y = 10'd20; px = 11'd0; py = 10'd0;
    step(3);
    checks++; if (obs_x !== {11'd640, 11'd400, 11'd160}) begin failures++; $display("FAIL reset_obs_x: got %h want %h", obs_x, {11'd640, 11'd400, 11'd160}); end
    checks++; if ({running, collide, item_taken, pix_obs, pix_item, pix_ch} !== 9'd0) begin failures++; $display("FAIL reset_outputs: got %b want 0", {running, collide, item_taken, pix_obs, pix_item, pix_ch}); end
    reset = 1'b1;
    step(3);
    checks++; if (obs_x !== {11'd640, 11'd400, 11'd160}) begin failures++; $display("FAIL idle_hold: got %h want %h", obs_x, {11'd640, 11'd400, 11'd160}); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL idle_running: got %b want 0", running); end
  endtask

  task automatic test_start_tick;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running: got %b want 1", running); end
    step(3);
    checks++; if (obs_x[10:0] !== 11'd160) begin failures++; $display("FAIL pre_tick: got %0d want 160", obs_x[10:0]); end
    step(1);
    checks++; if (obs_x !== {11'd639, 11'd399, 11'd159}) begin failures++; $display("FAIL first_tick: got %h want %h", obs_x, {11'd639, 11'd399, 11'd159}); end
  endtask

  task automatic test_pickup;
    player_x = 11'd185; player_y = 10'd270;
    step(1);
    checks++; if (item_taken !== 3'b001) begin failures++; $display("FAIL pickup_pulse: got %b want 001", item_taken); end
    px = 11'd190; py = 10'd260;
    step(1);
    checks++; if (item_taken !== 3'b000) begin failures++; $display("FAIL pickup_one_shot: got %b want 000", item_taken); end
    checks++; if ({pix_obs, pix_item} !== 2'b00) begin failures++; $display("FAIL pix_consumed: got %b want 00", {pix_obs, pix_item}); end
    step(1);
    checks++; if (item_taken !== 3'b000) begin failures++; $display("FAIL pickup_persist: got %b want 000", item_taken); end
    player_x = 11'd0; player_y = 10'd20;
    step(1);
    checks++; if (obs_x[10:0] !== 11'd158) begin failures++; $display("FAIL pickup_scroll: got %0d want 158", obs_x[10:0]); end
  endtask

  task automatic test_pixel_sweep;
    px = 11'd170; py = 10'd399;
    step(1);
    checks++; if ({pix_obs, pix_item, pix_ch} !== 5'b10_000) begin failures++; $display("FAIL pix_tree_bottom: got %b want 10000", {pix_obs, pix_item, pix_ch}); end
    py = 10'd400;
    step(1);
    checks++; if (pix_obs !== 1'b0) begin failures++; $display("FAIL pix_ground: got %b want 0", pix_obs); end
    px = 11'd420; py = 10'd399;
    step(1);
    checks++; if ({pix_obs, pix_ch} !== 4'b1_001) begin failures++; $display("FAIL pix_lane1: got %b want 1001", {pix_obs, pix_ch}); end
    px = 11'd660; py = 10'd260;
    step(1);
    checks++; if ({pix_obs, pix_item, pix_ch} !== 5'b01_010) begin failures++; $display("FAIL pix_banana2: got %b want 01010", {pix_obs, pix_item, pix_ch}); end
    checks++; if (obs_x !== {11'd637, 11'd397, 11'd157}) begin failures++; $display("FAIL sweep_obs: got %h want %h", obs_x, {11'd637, 11'd397, 11'd157}); end
    px = 11'd0; py = 10'd0;
  endtask

  task automatic test_respawn;
    speed = 2'd2;
    step(237);
    checks++; if (obs_x !== {11'd400, 11'd160, 11'h7B0}) begin failures++; $display("FAIL at_edge: got %h want %h", obs_x, {11'd400, 11'd160, 11'h7B0}); end
    freeze = 1'b1;
    step(1);
    checks++; if (obs_x !== {11'd399, 11'd159, 11'd640}) begin failures++; $display("FAIL respawn: got %h want %h", obs_x, {11'd399, 11'd159, 11'd640}); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running: got %b want 0", running); end
    px = 11'd650; py = 10'd374;
    step(1);
    checks++; if ({pix_obs, pix_ch} !== 4'b1_000) begin failures++; $display("FAIL new_top: got %b want 1000", {pix_obs, pix_ch}); end
    py = 10'd373;
    step(1);
    checks++; if ({pix_obs, pix_item} !== 2'b00) begin failures++; $display("FAIL above_top: got %b want 00", {pix_obs, pix_item}); end
    px = 11'd670; py = 10'd343;
    step(1);
    checks++; if ({pix_obs, pix_item, pix_ch} !== 5'b01_000) begin failures++; $display("FAIL consumed_cleared: got %b want 01000", {pix_obs, pix_item, pix_ch}); end
    px = 11'd0; py = 10'd0;
  endtask

  task automatic test_freeze;
    speed = 2'd0; freeze = 1'b0;
    step(1);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume: got %b want 1", running); end
    step(2);
    freeze = 1'b1;
    step(20);
    checks++; if ({running, obs_x} !== {1'b0, 11'd399, 11'd159, 11'd640}) begin failures++; $display("FAIL frozen: got %h want %h", {running, obs_x}, {1'b0, 11'd399, 11'd159, 11'd640}); end
    freeze = 1'b0;
    step(1);
    checks++; if ({running, obs_x[10:0]} !== {1'b1, 11'd640}) begin failures++; $display("FAIL unfreeze_hold: got %h want %h", {running, obs_x[10:0]}, {1'b1, 11'd640}); end
    step(1);
    checks++; if (obs_x !== {11'd398, 11'd158, 11'd639}) begin failures++; $display("FAIL unfreeze_tick: got %h want %h", obs_x, {11'd398, 11'd158, 11'd639}); end
  endtask

  task automatic test_collision;
    player_x = 11'd185; player_y = 10'd310;
    step(1);
    checks++; if ({collide, item_taken, running} !== 5'b1_000_0) begin failures++; $display("FAIL collide: got %b want 10000", {collide, item_taken, running}); end
    player_x = 11'd0; player_y = 10'd20;
    step(6);
    checks++; if ({collide, obs_x} !== {1'b1, 11'd398, 11'd158, 11'd639}) begin failures++; $display("FAIL halt_frozen: got %h want %h", {collide, obs_x}, {1'b1, 11'd398, 11'd158, 11'd639}); end
    start = 1'b1;
    step(1);
    checks++; if ({running, collide, obs_x} !== {2'b10, 11'd640, 11'd400, 11'd160}) begin failures++; $display("FAIL restart: got %h want %h", {running, collide, obs_x}, {2'b10, 11'd640, 11'd400, 11'd160}); end
    px = 11'd170; py = 10'd257;
    step(1);
    checks++; if ({pix_obs, pix_ch} !== 4'b1_000) begin failures++; $display("FAIL restart_top: got %b want 1000", {pix_obs, pix_ch}); end
    py = 10'd256;
    step(1);
    checks++; if (pix_obs !== 1'b0) begin failures++; $display("FAIL restart_above: got %b want 0", pix_obs); end
    step(2);
    checks++; if ({running, obs_x} !== {1'b1, 11'd639, 11'd399, 11'd159}) begin failures++; $display("FAIL start_in_run: got %h want %h", {running, obs_x}, {1'b1, 11'd639, 11'd399, 11'd159}); end
    start = 1'b0;
  endtask

  initial begin
    test_reset;
    test_start_tick;
    test_pickup;
    test_pixel_sweep;
    test_respawn;
    test_freeze;
    test_collision;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
Parametrised obstacle engine for the side-scroller: NUM_OBS tree lanes scroll left at a selectable speed. Each tree has an LFSR-generated height and a collectible banana above it. The block performs player collision and banana pickup, and returns a registered per-pixel classification to the VGA colour mux. It replaces the fixed three-tree scroll/height logic with a run/pause/halt state machine, per-lane respawn and one-shot pickup pulses.

Parameters:
NUM_OBS, 3, number of tree lanes (1..8)
X_W, 11, signed x-coordinate width
Y_W, 10, y-coordinate width
SCREEN_W, 640, visible width
GROUND_Y, 400, first grass row; tree bottom is GROUND_Y-1
OBS_W, 80, tree width in pixels
SPACING, 240, initial lane pitch; wrap period is NUM_OBS*SPACING
FIRST_X, 160, initial x_left of lane 0
H_MIN, 140, minimum tree top y
H_RANGE_LOG2, 8, tree top y = H_MIN + lfsr[H_RANGE_LOG2-1:0]
ITEM_INSET, 20, banana x inset from each tree edge
ITEM_GAP, 30, rows between banana bottom and tree top
ITEM_H, 30, banana height
PLAYER_SZ, 30, square player size
PRESCALE, 500000, clocks per scroll step at speed 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  level; begin or restart the game
freeze  in  1  level; pause scrolling while high
speed  in  2  scroll-rate select; step period = PRESCALE>>speed clocks
player_x  in  X_W  player left x
player_y  in  Y_W  player bottom y
px  in  X_W  pixel x query
py  in  Y_W  pixel y query
pix_obs  out  1  queried pixel lies on a tree
pix_item  out  1  queried pixel lies on an unconsumed banana
pix_ch  out  3  lowest lane index that matched
collide  out  1  sticky; player hit a tree
item_taken  out  NUM_OBS  one-cycle pickup pulse per lane
running  out  1  high in RUN
obs_x  out  NUM_OBS*X_W  packed x_left per lane, lane 0 in the LSBs

Behaviour:
- Reset (async, low): state IDLE; x_left[i] = FIRST_X + i*SPACING; lfsr[i] = 8'hA5 ^ i (never 0); top[i] = H_MIN + lfsr[i] slice; consumed = 0; prescaler = 0. All outputs are 0 except obs_x, which carries the initial positions.
- States:
  - IDLE -> RUN on start.
  - RUN -> PAUSE while freeze is high.
  - PAUSE -> RUN when freeze is low.
  - RUN -> HALT on collision.
  - HALT -> RUN on start, with re-init.
  - start is ignored in RUN and PAUSE.
- Re-init on HALT->RUN: positions return to their reset values; each LFSR steps once and reloads its height; consumed, collide and prescaler are cleared.
- LFSR: 8-bit Galois, taps 0xB8, steps once per respawn or re-init.
- Prescaler: counts only in RUN. tick = (count == (PRESCALE>>speed)-1); on tick the counter returns to 0. A speed change mid-count takes effect immediately; if count already exceeds the new terminal, tick at the next wrap of the counter width. The counter holds in PAUSE, HALT and IDLE.
- Scroll on tick, per lane:
  - if x_left == -OBS_W: x_left <= NUM_OBS*SPACING-OBS_W, lfsr steps, top reloads, consumed <= 0;
  - else x_left <= x_left-1.
  - Lanes are independent; simultaneous respawns are allowed.
- Geometry, all bounds inclusive:
  - tree: x in [x_left, x_left+OBS_W-1], y in [top, GROUND_Y-1].
  - banana: x in [x_left+ITEM_INSET, x_left+OBS_W-1-ITEM_INSET], y in [top-ITEM_GAP-ITEM_H, top-ITEM_GAP-1].
  - player: x in [player_x, player_x+PLAYER_SZ-1], y in [player_y-PLAYER_SZ+1, player_y].
- Collision, evaluated every clock in RUN:
  - any player/tree rectangle overlap -> collide <= 1 and HALT next cycle.
  - Otherwise, any overlap with an unconsumed banana -> item_taken[i] pulses 1 cycle and consumed[i] <= 1.
  - Collision has priority: no pickup pulse in the cycle a collision is detected.
  - Multiple lanes may pulse together.
  - Latency: 1 cycle from input/position change to output.
- Pixel path: registered, 1-cycle latency, active in every state.
  - pix_item = banana hit && !consumed.
  - pix_ch = lowest matching lane, 0 if none.
  - Pixels left of 0 never match because px is non-negative.
- Parameter check: NUM_OBS*SPACING-OBS_W >= SCREEN_W, else elaboration error.

Decomposition:
- Package scroller_pkg: state enum (IDLE, RUN, PAUSE, HALT), LFSR tap constant, LFSR seed base, rectangle-overlap function.
- Sub-module obstacle_lane, one instance per lane, generated. Holds x_left, lfsr, top and consumed; produces tree/banana overlap flags against the player and the pixel query.
- The top level holds the FSM, prescaler, priority encode and output registers.

Test Plan:
- Reset with PRESCALE=4, speed=0, start high for 1 cycle -> running=1 after 1 cycle; obs_x[0] goes 160->159 after 4 clocks; lanes 1 and 2 at 399 and 639.
- Step lane 0 to x_left=-80 and tick once -> x_left=640, new top = 140 + stepped-LFSR slice, consumed cleared.
- Player at (x=185, y=top0-35), clear of the tree -> item_taken=001 for exactly 1 cycle; no further pulse while overlap persists; pix_item=0 over that banana afterwards.
- Player overlapping a tree and a banana in the same cycle -> collide=1, item_taken=0, HALT next cycle, obs_x frozen; start -> positions 160/400/640 and collide=0.
- freeze high for 20 clocks mid-count -> obs_x unchanged and prescaler holds; on release the tick arrives after the remaining count; speed=2 gives period 1 clock.
- Pixel sweep px=170, py=GROUND_Y-1 -> pix_obs=1, pix_ch=0 one cycle later; py=GROUND_Y -> pix_obs=0.
